// File: rtl/b9_resp_compactor.sv
// -----------------------------------------------------------------------------
// b9_resp_compactor
//
// Response compaction stage behind the b9 control-logic block. Each 21-bit b9
// output word accepted on a valid/ready handshake is folded into a Galois
// multiple-input signature register (MISR). After the programmed number of
// words the block stops, holds the signature and reports pass/fail against a
// golden signature captured at start.
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle pulse, starts a run (accepted in IDLE or DONE only)
//   abort      : returns to IDLE on the next edge, signature/vec_count held
//   num_vec    : number of words in the run, captured on an accepted start
//   golden     : expected final signature, captured on an accepted start
//   in_valid   : upstream word valid
//   in_ready   : block accepts a word this cycle (decoded from state, RUN)
//   in_data    : upstream response word
//   busy       : registered, high while in RUN
//   done       : registered, high while in DONE
//   pass       : registered, in DONE: final signature == golden
//   signature  : current MISR contents
//   vec_count  : words accepted in the current run
// -----------------------------------------------------------------------------
module b9_resp_compactor #(
    parameter int                 RESP_W = 21,
    parameter int                 CNT_W  = 16,
    parameter logic [RESP_W-1:0]  SEED   = 21'h000000,
    parameter logic [RESP_W-1:0]  POLY   = 21'h000005
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic [RESP_W-1:0] golden,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RESP_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [RESP_W-1:0] signature,
    output logic [CNT_W-1:0]  vec_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One MISR step: shift left, apply feedback taps when the MSB falls out,
    // then fold in the incoming word.
    function automatic logic [RESP_W-1:0] misr_step(
        input logic [RESP_W-1:0] sig,
        input logic [RESP_W-1:0] data
    );
        logic [RESP_W-1:0] fb;
        fb = sig[RESP_W-1] ? POLY : {RESP_W{1'b0}};
        return {sig[RESP_W-2:0], 1'b0} ^ fb ^ data;
    endfunction

    state_t            state_q, state_d;
    logic [RESP_W-1:0] sig_q,   sig_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [CNT_W-1:0]  num_q,   num_d;
    logic [RESP_W-1:0] gold_q,  gold_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              pass_q,  pass_d;

    logic [RESP_W-1:0] sig_next_s;
    logic [CNT_W-1:0]  cnt_next_s;

    // Next-state and datapath update: abort beats start and transfer.
    always_comb begin
        state_d    = state_q;
        sig_d      = sig_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        gold_d     = gold_q;
        pass_d     = pass_q;
        sig_next_s = misr_step(sig_q, in_data);
        cnt_next_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

        if (abort) begin
            state_d = S_IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        num_d  = num_vec;
                        gold_d = golden;
                        sig_d  = SEED;
                        cnt_d  = {CNT_W{1'b0}};
                        if (num_vec == {CNT_W{1'b0}}) begin
                            // Empty run: the seed itself is the final signature.
                            state_d = S_DONE;
                            pass_d  = (SEED == golden);
                        end else begin
                            state_d = S_RUN;
                            pass_d  = 1'b0;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        sig_d = sig_next_s;
                        cnt_d = cnt_next_s;
                        if (cnt_next_s == num_q) begin
                            // Last word: finish on this same edge so in_ready
                            // drops before any extra word can be taken.
                            state_d = S_DONE;
                            pass_d  = (sig_next_s == gold_q);
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= {CNT_W{1'b0}};
            num_q   <= {CNT_W{1'b0}};
            gold_q  <= {RESP_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            gold_q  <= gold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign in_ready  = (state_q == S_RUN);
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;
    assign vec_count = cnt_q;

endmodule

// File: tb/tb_b9_resp_compactor.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for b9_resp_compactor.
// -----------------------------------------------------------------------------
module tb_b9_resp_compactor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] num_vec;
    logic [20:0] golden;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] in_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [20:0] signature;
    logic [15:0] vec_count;

    int n_tests;
    int n_fail;

    b9_resp_compactor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .num_vec   (num_vec),
        .golden    (golden),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature),
        .vec_count (vec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference MISR step: x^21 + x^2 + 1 Galois form.
    function automatic logic [20:0] ref_step(input logic [20:0] s, input logic [20:0] d);
        logic [21:0] sh;
        sh = {s, 1'b0};
        return sh[20:0] ^ (sh[21] ? 21'h000005 : 21'h000000) ^ d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n, input logic [20:0] g);
        start   = 1'b1;
        num_vec = n;
        golden  = g;
        step();
        start   = 1'b0;
    endtask

    task automatic send(input logic [20:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    logic [20:0] vdata [10];
    logic        vvalid[10];
    logic [20:0] model_sig;
    int          model_cnt;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        num_vec  = 16'd0;
        golden   = 21'd0;
        in_valid = 1'b0;
        in_data  = 21'd0;

        // Reset state
        #12;
        chk("rst_sig",   32'(signature), 32'h0);
        chk("rst_cnt",   32'(vec_count), 32'h0);
        chk("rst_ready", 32'(in_ready),  32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_done",  32'(done),      32'h0);
        chk("rst_pass",  32'(pass),      32'h0);
        #1 rst_n = 1'b1;
        step();

        // Single-word run
        do_start(16'd1, 21'h000001);
        chk("t1_busy",  32'(busy),     32'h1);
        chk("t1_ready", 32'(in_ready), 32'h1);
        send(21'h000001);
        chk("t1_sig",   32'(signature), 32'h000001);
        chk("t1_cnt",   32'(vec_count), 32'h1);
        chk("t1_done",  32'(done),      32'h1);
        chk("t1_pass",  32'(pass),      32'h1);
        chk("t1_ready0",32'(in_ready),  32'h0);
        chk("t1_busy0", 32'(busy),      32'h0);

        // Feedback taps
        do_start(16'd2, 21'h000004);
        chk("t2_reseed", 32'(signature), 32'h0);
        send(21'h100000);
        chk("t2_sig1",  32'(signature), 32'h100000);
        chk("t2_done1", 32'(done),      32'h0);
        send(21'h000000);
        chk("t2_sig2",  32'(signature), 32'h000005);
        chk("t2_done",  32'(done),      32'h1);
        chk("t2_pass",  32'(pass),      32'h0);

        // Empty run
        do_start(16'd0, 21'h000000);
        chk("t3_done",  32'(done),      32'h1);
        chk("t3_pass",  32'(pass),      32'h1);
        chk("t3_cnt",   32'(vec_count), 32'h0);
        chk("t3_ready", 32'(in_ready),  32'h0);
        chk("t3_busy",  32'(busy),      32'h0);

        // Back-pressure and gaps: only the first four valid words count
        vdata  = '{21'h0ABCDE, 21'h1FFFFF, 21'h123456, 21'h000F0F, 21'h155555,
                   21'h0AAAAA, 21'h1E0001, 21'h0DEAD0, 21'h1BEEF0, 21'h00C0DE};
        vvalid = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        model_sig = 21'h0;
        model_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (vvalid[i] && model_cnt < 4) begin
                model_sig = ref_step(model_sig, vdata[i]);
                model_cnt++;
            end
        end
        do_start(16'd4, model_sig);
        for (int i = 0; i < 10; i++) begin
            in_valid = vvalid[i];
            in_data  = vdata[i];
            step();
        end
        chk("t4_sig",   32'(signature), 32'(model_sig));
        chk("t4_cnt",   32'(vec_count), 32'h4);
        chk("t4_done",  32'(done),      32'h1);
        chk("t4_pass",  32'(pass),      32'h1);
        in_valid = 1'b1;
        in_data  = 21'h1FFFFF;
        step();
        chk("t4_ready5", 32'(in_ready),  32'h0);
        chk("t4_cnt5",   32'(vec_count), 32'h4);
        chk("t4_sig5",   32'(signature), 32'(model_sig));
        in_valid = 1'b0;

        // Abort on the second word of a three-word run
        do_start(16'd3, 21'h000000);
        send(21'h012345);
        in_valid = 1'b1;
        in_data  = 21'h0FFFFF;
        abort    = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("t5_cnt",   32'(vec_count), 32'h1);
        chk("t5_sig",   32'(signature), 32'h012345);
        chk("t5_busy",  32'(busy),      32'h0);
        chk("t5_done",  32'(done),      32'h0);
        chk("t5_pass",  32'(pass),      32'h0);
        chk("t5_ready", 32'(in_ready),  32'h0);
        do_start(16'd1, 21'h000000);
        chk("t5_reseed", 32'(signature), 32'h0);
        chk("t5_recnt",  32'(vec_count), 32'h0);
        send(21'h000000);
        chk("t5_pass2", 32'(pass), 32'h1);

        // Asynchronous reset in the middle of a run
        do_start(16'd2, 21'h000000);
        send(21'h000003);
        chk("t6_pre", 32'(signature), 32'h000003);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_sig",   32'(signature), 32'h0);
        chk("t6_cnt",   32'(vec_count), 32'h0);
        chk("t6_busy",  32'(busy),      32'h0);
        chk("t6_ready", 32'(in_ready),  32'h0);
        #10 rst_n = 1'b1;
        step();
        do_start(16'd1, 21'h000007);
        send(21'h000007);
        chk("t6_sig2",  32'(signature), 32'h000007);
        chk("t6_done",  32'(done),      32'h1);
        chk("t6_pass",  32'(pass),      32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
